// File: rtl/greedy_snake_body_sched.sv
// greedy_snake_body_sched: snake-body update engine and BSRAM arbiter.
// Each step pulse computes the next head, checks walls, scans the body for a
// self-hit, then pushes the new head into a circular segment buffer.
// The video reader shares the single-port BSRAM in IDLE and OVER only.
// Optional feature: define GREEDY_SNAKE_WRAP_EN to wrap at the walls instead of ending the game.
//
// Video handshake: vid_req is a level request with vid_idx held stable; vid_gnt
// is asserted in the cycle the request is accepted (IDLE or OVER, no step pending,
// not in reset); vid_valid/vid_data/vid_live follow exactly one cycle after vid_gnt.
// A request that is not granted must be held by the requester; nothing is queued.
module greedy_snake_body_sched #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int MAX_LEN  = 64,
  parameter int ADDR_W   = 6,
  parameter int INIT_LEN = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic [1:0]         forward,
  input  logic [3:0]         mode,
  input  logic [X_W-1:0]     food_x,
  input  logic [Y_W-1:0]     food_y,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_wr,
  output logic [X_W+Y_W-1:0] ram_wdata,
  input  logic [X_W+Y_W-1:0] ram_rdata,
  input  logic               vid_req,
  input  logic [ADDR_W-1:0]  vid_idx,
  output logic               vid_gnt,
  output logic               vid_valid,
  output logic [X_W+Y_W-1:0] vid_data,
  output logic               vid_live,
  output logic [X_W-1:0]     head_x,
  output logic [Y_W-1:0]     head_y,
  output logic [ADDR_W:0]    length,
  output logic               ate,
  output logic               game_over,
  output logic               busy
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [X_W-1:0]   INIT_HX   = X_W'(INIT_LEN - 1);
  localparam logic [Y_W-1:0]   INIT_HY   = Y_W'(GRID_H / 2);
  localparam logic [X_W-1:0]   X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_INIT  = LEN_W'(INIT_LEN);
`ifdef GREEDY_SNAKE_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CALC, S_SCAN, S_WRITE, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;         // INIT write index / SCAN cycle index
  logic [LEN_W-1:0]   n_q, n_d;             // segments to scan this step
  logic [ADDR_W-1:0]  head_ptr_q, head_ptr_d;
  logic [X_W-1:0]     head_x_q, head_x_d, nxt_x_q, nxt_x_d;
  logic [Y_W-1:0]     head_y_q, head_y_d, nxt_y_q, nxt_y_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic               grow_q, grow_d, hit_q, hit_d;
  logic               game_over_q, game_over_d, ate_q, ate_d;
  logic               vid_valid_q, vid_valid_d, vid_live_q, vid_live_d;
  logic               ram_wr_c, gnt_c, match_now;
  logic [X_W-1:0]     calc_x;
  logic [Y_W-1:0]     calc_y;
  logic               off_grid, wall_hit;

  // Candidate next head; off_grid flags a wall crossing, calc_* holds the wrapped cell.
  always_comb begin
    calc_x   = head_x_q;
    calc_y   = head_y_q;
    off_grid = 1'b0;
    case (forward)
      2'b00: if (head_x_q == X_MAX) begin off_grid = 1'b1; calc_x = '0; end
             else calc_x = head_x_q + X_W'(1);
      2'b01: if (head_x_q == '0) begin off_grid = 1'b1; calc_x = X_MAX; end
             else calc_x = head_x_q - X_W'(1);
      2'b10: if (head_y_q == Y_MAX) begin off_grid = 1'b1; calc_y = '0; end
             else calc_y = head_y_q + Y_W'(1);
      default: if (head_y_q == '0) begin off_grid = 1'b1; calc_y = Y_MAX; end
               else calc_y = head_y_q - Y_W'(1);
    endcase
    wall_hit = off_grid & ~WRAP_EN;
  end

  // Next-state, BSRAM port and grant logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    head_ptr_d  = head_ptr_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    nxt_x_d     = nxt_x_q;
    nxt_y_d     = nxt_y_q;
    length_d    = length_q;
    grow_d      = grow_q;
    hit_d       = hit_q;
    game_over_d = game_over_q;
    ate_d       = 1'b0;
    ram_addr    = '0;
    ram_wr_c    = 1'b0;
    ram_wdata   = '0;
    gnt_c       = 1'b0;
    match_now   = (cnt_q != '0) && (ram_rdata == {nxt_y_q, nxt_x_q});
    case (state_q)
      S_INIT: begin
        ram_wr_c  = 1'b1;
        ram_addr  = ADDR_W'(cnt_q);
        ram_wdata = {INIT_HY, INIT_HX - X_W'(cnt_q)};
        if (cnt_q == LEN_INIT - LEN_W'(1)) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          length_d = LEN_INIT;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_IDLE, S_OVER: begin
        if (mode == 4'd0) begin
          state_d     = S_INIT;
          cnt_d       = '0;
          head_ptr_d  = '0;
          head_x_d    = INIT_HX;
          head_y_d    = INIT_HY;
          length_d    = '0;
          game_over_d = 1'b0;
        end else if (step_en && state_q == S_IDLE) begin
          state_d = S_CALC;
        end else if (vid_req) begin
          gnt_c    = 1'b1;
          ram_addr = head_ptr_q + vid_idx;
        end
      end
      S_CALC: begin
        if (wall_hit) begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end else begin
          nxt_x_d = calc_x;
          nxt_y_d = calc_y;
          grow_d  = (calc_x == food_x) && (calc_y == food_y);
          n_d     = grow_d ? length_q : length_q - LEN_W'(1);
          cnt_d   = '0;
          hit_d   = 1'b0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (cnt_q < n_q) ram_addr = head_ptr_q + ADDR_W'(cnt_q);
        if (cnt_q == n_q) begin
          if (hit_q || match_now) begin
            game_over_d = 1'b1;
            state_d     = S_OVER;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          hit_d = hit_q | match_now;
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_WRITE: begin
        head_ptr_d = head_ptr_q - ADDR_W'(1);
        ram_wr_c   = 1'b1;
        ram_addr   = head_ptr_q - ADDR_W'(1);
        ram_wdata  = {nxt_y_q, nxt_x_q};
        head_x_d   = nxt_x_q;
        head_y_d   = nxt_y_q;
        if (grow_q) begin
          ate_d = 1'b1;
          if (length_q != LEN_FULL) length_d = length_q + LEN_W'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    vid_valid_d = gnt_c;
    vid_live_d  = gnt_c && ({1'b0, vid_idx} < length_q);
  end

  // State and datapath registers with synchronous reset into INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      n_q         <= '0;
      head_ptr_q  <= '0;
      head_x_q    <= INIT_HX;
      head_y_q    <= INIT_HY;
      nxt_x_q     <= '0;
      nxt_y_q     <= '0;
      length_q    <= '0;
      grow_q      <= 1'b0;
      hit_q       <= 1'b0;
      game_over_q <= 1'b0;
      ate_q       <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_live_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      head_ptr_q  <= head_ptr_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      nxt_x_q     <= nxt_x_d;
      nxt_y_q     <= nxt_y_d;
      length_q    <= length_d;
      grow_q      <= grow_d;
      hit_q       <= hit_d;
      game_over_q <= game_over_d;
      ate_q       <= ate_d;
      vid_valid_q <= vid_valid_d;
      vid_live_q  <= vid_live_d;
    end
  end

  // Reset masks the strobes so an in-flight write or grant is dropped at once.
  assign ram_wr    = ram_wr_c & ~rst;
  assign vid_gnt   = gnt_c & ~rst;
  assign vid_valid = vid_valid_q;
  assign vid_live  = vid_live_q;
  assign vid_data  = vid_valid_q ? ram_rdata : '0;
  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign length    = length_q;
  assign ate       = ate_q;
  assign game_over = game_over_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_OVER);

endmodule

// File: tb/tb_greedy_snake_body_sched.sv
// Directed bench for greedy_snake_body_sched with a behavioural BSRAM.
module tb_greedy_snake_body_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_en = 1'b0;
  logic [1:0] forward = 2'd0;
  logic [3:0] mode = 4'd1;
  logic [4:0] food_x = 5'd20;
  logic [4:0] food_y = 5'd20;
  logic [5:0] ram_addr;
  logic       ram_wr;
  logic [9:0] ram_wdata;
  logic [9:0] ram_rdata;
  logic       vid_req = 1'b0;
  logic [5:0] vid_idx = 6'd0;
  logic       vid_gnt, vid_valid, vid_live, ate, game_over, busy;
  logic [9:0] vid_data;
  logic [4:0] head_x, head_y;
  logic [6:0] length;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] fwd;
    logic [4:0] fx, fy;
    logic [4:0] hx, hy;
    logic [6:0] len;
    logic       ate, over, wr;
    logic [5:0] waddr;
    int         lat;
  } step_vec_t;

  typedef struct {
    logic [5:0] idx;
    logic [5:0] addr;
    logic [9:0] data;
    logic       live;
  } vid_vec_t;

  step_vec_t  tbl[5];
  vid_vec_t   vtbl[5];
  logic [9:0] init_data[3];
  logic [9:0] mem[64];

  greedy_snake_body_sched dut (
    .clk(clk), .rst(rst), .step_en(step_en), .forward(forward), .mode(mode),
    .food_x(food_x), .food_y(food_y), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .vid_req(vid_req), .vid_idx(vid_idx),
    .vid_gnt(vid_gnt), .vid_valid(vid_valid), .vid_data(vid_data), .vid_live(vid_live),
    .head_x(head_x), .head_y(head_y), .length(length), .ate(ate),
    .game_over(game_over), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // single-port BSRAM, read data one cycle after the address
  initial for (int i = 0; i < 64; i++) mem[i] = 10'h3FF;
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: one step pulse, then follow until busy drops
  task automatic run_step(input string tag, input step_vec_t v);
    int cyc, nwr;
    logic [5:0] wa;
    logic [9:0] wd;
    bit done;
    @(posedge clk); #1;
    forward = v.fwd; food_x = v.fx; food_y = v.fy; step_en = 1'b1;
    @(posedge clk); #1;
    step_en = 1'b0;
    cyc = 0; nwr = 0; wa = '0; wd = '0; done = 1'b0;
    for (int k = 1; k <= 300 && !done; k++) begin
      @(negedge clk);
      if (ram_wr) begin nwr++; wa = ram_addr; wd = ram_wdata; end
      if (!busy) begin done = 1'b1; cyc = k; end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(v.lat));
    check({tag, "_nwr"}, 32'(nwr), v.wr ? 32'd1 : 32'd0);
    if (v.wr) begin
      check({tag, "_waddr"}, 32'(wa), 32'(v.waddr));
      check({tag, "_wdata"}, 32'(wd), 32'({v.hy, v.hx}));
    end
    check({tag, "_head"}, 32'({head_y, head_x}), 32'({v.hy, v.hx}));
    check({tag, "_len"}, 32'(length), 32'(v.len));
    check({tag, "_ate"}, 32'(ate), 32'(v.ate));
    check({tag, "_over"}, 32'(game_over), 32'(v.over));
  endtask

  // driver: one video read, checked on grant and on the following cycle
  task automatic vid_read(input string tag, input vid_vec_t v);
    @(posedge clk); #1;
    vid_req = 1'b1; vid_idx = v.idx;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(vid_gnt), 32'd1);
    check({tag, "_addr"}, 32'(ram_addr), 32'(v.addr));
    @(posedge clk); #1;
    vid_req = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, 32'(vid_valid), 32'd1);
    check({tag, "_live"}, 32'(vid_live), 32'(v.live));
    if (v.live) check({tag, "_data"}, 32'(vid_data), 32'(v.data));
  endtask

  // driver: mode=0 for one cycle, then wait for INIT to finish
  task automatic reinit(input string tag);
    int cyc, nwr;
    bit done;
    @(posedge clk); #1; mode = 4'd0;
    @(posedge clk); #1; mode = 4'd1;
    cyc = 0; nwr = 0; done = 1'b0;
    for (int k = 1; k <= 50 && !done; k++) begin
      @(negedge clk);
      if (ram_wr) nwr++;
      if (!busy) begin done = 1'b1; cyc = k; end
    end
    check({tag, "_lat"}, 32'(cyc), 32'd4);
    check({tag, "_nwr"}, 32'(nwr), 32'd3);
    check({tag, "_len"}, 32'(length), 32'd3);
    check({tag, "_head"}, 32'({head_y, head_x}), 32'({5'd12, 5'd2}));
    check({tag, "_over"}, 32'(game_over), 32'd0);
  endtask

  initial begin
    int cyc, nwr, gnt_busy, nbusy;
    logic [5:0] wa, hp;
    logic [9:0] wd;
    bit done;
    step_vec_t v;

    init_data[0] = {5'd12, 5'd2};
    init_data[1] = {5'd12, 5'd1};
    init_data[2] = {5'd12, 5'd0};

    vtbl[0] = '{idx: 6'd0,  addr: 6'd0,  data: {5'd12, 5'd2}, live: 1'b1};
    vtbl[1] = '{idx: 6'd1,  addr: 6'd1,  data: {5'd12, 5'd1}, live: 1'b1};
    vtbl[2] = '{idx: 6'd2,  addr: 6'd2,  data: {5'd12, 5'd0}, live: 1'b1};
    vtbl[3] = '{idx: 6'd5,  addr: 6'd5,  data: 10'd0,         live: 1'b0};
    vtbl[4] = '{idx: 6'd63, addr: 6'd63, data: 10'd0,         live: 1'b0};

    // after a fresh INIT: head (2,12), head_ptr 0
    tbl[0] = '{fwd: 2'd0, fx: 5'd3,  fy: 5'd12, hx: 5'd3, hy: 5'd12, len: 7'd4,
               ate: 1'b1, over: 1'b0, wr: 1'b1, waddr: 6'd63, lat: 7};  // eat, n=3
    tbl[1] = '{fwd: 2'd2, fx: 5'd20, fy: 5'd20, hx: 5'd3, hy: 5'd13, len: 7'd4,
               ate: 1'b0, over: 1'b0, wr: 1'b1, waddr: 6'd62, lat: 7};
    tbl[2] = '{fwd: 2'd1, fx: 5'd20, fy: 5'd20, hx: 5'd2, hy: 5'd13, len: 7'd4,
               ate: 1'b0, over: 1'b0, wr: 1'b1, waddr: 6'd61, lat: 7};
    tbl[3] = '{fwd: 2'd3, fx: 5'd20, fy: 5'd20, hx: 5'd2, hy: 5'd12, len: 7'd4,
               ate: 1'b0, over: 1'b0, wr: 1'b1, waddr: 6'd60, lat: 7};  // onto moving tail: safe
    tbl[4] = '{fwd: 2'd0, fx: 5'd3,  fy: 5'd12, hx: 5'd2, hy: 5'd12, len: 7'd4,
               ate: 1'b0, over: 1'b1, wr: 1'b0, waddr: 6'd0,  lat: 7};  // food on body: hit

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_vid_gnt", 32'(vid_gnt), 32'd0);
    check("rst_vid_valid", 32'(vid_valid), 32'd0);
    check("rst_ate", 32'(ate), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_len", 32'(length), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_head", 32'({head_y, head_x}), 32'({5'd12, 5'd2}));

    // INIT writes after reset release
    @(posedge clk); #1; rst = 1'b0;
    nwr = 0; cyc = 0; done = 1'b0;
    for (int k = 1; k <= 50 && !done; k++) begin
      @(negedge clk);
      if (ram_wr) begin
        if (nwr < 3) begin
          check($sformatf("init_addr%0d", nwr), 32'(ram_addr), nwr);
          check($sformatf("init_data%0d", nwr), 32'(ram_wdata), 32'(init_data[nwr]));
        end
        nwr++;
      end
      if (!busy) begin done = 1'b1; cyc = k; end
    end
    check("init_nwr", 32'(nwr), 32'd3);
    check("init_busy_low_cycle", 32'(cyc), 32'd4);
    check("init_len", 32'(length), 32'd3);

    // video reads in IDLE
    for (int i = 0; i < 5; i++) vid_read($sformatf("vid%0d", i), vtbl[i]);

    // step with a simultaneous held video request: step wins, grant after busy
    @(posedge clk); #1;
    forward = 2'd0; food_x = 5'd20; food_y = 5'd20;
    step_en = 1'b1; vid_req = 1'b1; vid_idx = 6'd1;
    @(negedge clk);
    check("conflict_gnt", 32'(vid_gnt), 32'd0);
    @(posedge clk); #1;
    step_en = 1'b0;
    nwr = 0; cyc = 0; gnt_busy = 0; done = 1'b0; wa = '0; wd = '0;
    for (int k = 1; k <= 100 && !done; k++) begin
      @(negedge clk);
      if (ram_wr) begin nwr++; wa = ram_addr; wd = ram_wdata; end
      if (busy) begin
        if (vid_gnt) gnt_busy++;
      end else begin
        done = 1'b1; cyc = k;
      end
    end
    check("step1_lat", 32'(cyc), 32'd6);
    check("step1_gnt_busy", 32'(gnt_busy), 32'd0);
    check("step1_nwr", 32'(nwr), 32'd1);
    check("step1_waddr", 32'(wa), 32'd63);
    check("step1_wdata", 32'(wd), 32'({5'd12, 5'd3}));
    check("step1_head", 32'({head_y, head_x}), 32'({5'd12, 5'd3}));
    check("step1_len", 32'(length), 32'd3);
    check("step1_ate", 32'(ate), 32'd0);
    check("held_req_gnt", 32'(vid_gnt), 32'd1);
    check("held_req_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1;
    vid_req = 1'b0;
    @(negedge clk);
    check("held_req_valid", 32'(vid_valid), 32'd1);
    check("held_req_data", 32'(vid_data), 32'({5'd12, 5'd2}));
    check("held_req_live", 32'(vid_live), 32'd1);

    // table-driven step sequence from a fresh snake, ending in self-collision
    reinit("reinit1");
    for (int i = 0; i < 5; i++) run_step($sformatf("tbl%0d", i), tbl[i]);

    // OVER: steps ignored, buffer frozen, video still served
    @(posedge clk); #1; forward = 2'd2; step_en = 1'b1;
    @(posedge clk); #1; step_en = 1'b0;
    nwr = 0; nbusy = 0;
    repeat (4) begin
      @(negedge clk);
      if (ram_wr) nwr++;
      if (busy) nbusy++;
    end
    check("over_busy", 32'(nbusy), 32'd0);
    check("over_nwr", 32'(nwr), 32'd0);
    check("over_head", 32'({head_y, head_x}), 32'({5'd12, 5'd2}));
    check("over_len", 32'(length), 32'd4);
    check("over_sticky", 32'(game_over), 32'd1);
    vid_read("over_vid0", '{idx: 6'd0, addr: 6'd60, data: {5'd12, 5'd2}, live: 1'b1});
    vid_read("over_vid4", '{idx: 6'd4, addr: 6'd0, data: 10'd0, live: 1'b0});

    // run east to the wall
    reinit("reinit2");
    hp = 6'd0;
    for (int i = 3; i <= 31; i++) begin
      hp = hp - 6'd1;
      v = '{fwd: 2'd0, fx: 5'd0, fy: 5'd0, hx: 5'(i), hy: 5'd12, len: 7'd3,
            ate: 1'b0, over: 1'b0, wr: 1'b1, waddr: hp, lat: 6};
      run_step($sformatf("east%0d", i), v);
    end
`ifdef GREEDY_SNAKE_WRAP_EN
    v = '{fwd: 2'd0, fx: 5'd0, fy: 5'd0, hx: 5'd0, hy: 5'd12, len: 7'd3,
          ate: 1'b0, over: 1'b0, wr: 1'b1, waddr: hp - 6'd1, lat: 6};
`else
    v = '{fwd: 2'd0, fx: 5'd0, fy: 5'd0, hx: 5'd31, hy: 5'd12, len: 7'd3,
          ate: 1'b0, over: 1'b1, wr: 1'b0, waddr: 6'd0, lat: 2};
`endif
    run_step("wall", v);
    reinit("reinit3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
